load_store_unit: RTL and testbench

Memory-stage load/store unit sitting directly upstream of the word-addressed data memory. Accepts byte-addressed load/store requests from the execute stage over a valid/ready handshake and converts them to word accesses. Performs byte/halfword stores by read-modify-write and sign/zero-extends loads. Returns one response per request over a valid/ready handshake to writeback, carrying the load data and an access-fault flag.

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 145 ++++++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signal bundle for the load/store unit.
// The LSU connects through the slave modport and its environment through the master modport.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [31:0]       mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte-addressed requests to word memory, RMW sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned H/HU/W accesses instead of aligning them down.
module load_store_unit #(
  parameter int MEM_WORDS = 1000,
  parameter int ADDR_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  load_store_unit_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] RMW_RD = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] RESP   = 3'd4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       merged_q, merged_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              fault;
  logic [ADDR_W-1:0] addr_aligned;
  logic              rd_en, wr_en;

  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] ofs);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{ofs, 3'b000} +: 8];
    h = word[{ofs[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'h0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [2:0] f3, input logic [1:0] ofs);
    logic [31:0] m;
    m = word;
    case (f3)
      F3_B:    m[{ofs, 3'b000} +: 8]    = wdata[7:0];
      F3_H:    m[{ofs[1], 4'b0000} +: 16] = wdata[15:0];
      default: m = wdata;
    endcase
    return m;
  endfunction

  always_comb begin
    fault = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
            (bus.req_funct3 == 3'b111) ||
            (bus.req_we && (bus.req_funct3 == F3_BU || bus.req_funct3 == F3_HU)) ||
            ((bus.req_addr >> 2) >= ADDR_W'(MEM_WORDS));
`ifdef LSU_MISALIGN_TRAP_EN
    if (((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU) && bus.req_addr[0]) ||
        (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00))
      fault = 1'b1;
`endif
    // Untrapped misaligned accesses silently drop the low offset bits
    case (bus.req_funct3)
      F3_H, F3_HU: addr_aligned = {bus.req_addr[ADDR_W-1:1], 1'b0};
      F3_W:        addr_aligned = {bus.req_addr[ADDR_W-1:2], 2'b00};
      default:     addr_aligned = bus.req_addr;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d   = addr_aligned;
          funct3_d = bus.req_funct3;
          merged_d = bus.req_wdata;
          rdata_d  = 32'h0;
          err_d    = fault;
          if (fault)                       state_d = RESP;
          else if (!bus.req_we)            state_d = LOAD;
          else if (bus.req_funct3 == F3_W) state_d = WRITE;
          else                             state_d = RMW_RD;
        end
      end
      LOAD: begin
        rdata_d = extend_load(bus.mem_rdata, funct3_q, addr_q[1:0]);
        state_d = RESP;
      end
      RMW_RD: begin
        // merged_q still holds the right-aligned store data here
        merged_d = merge_store(bus.mem_rdata, merged_q, funct3_q, addr_q[1:0]);
        state_d  = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q   <= addr_d;
    funct3_q <= funct3_d;
    merged_q <= merged_d;
  end

  // Reset gates the memory strobes so an interrupted RMW never commits
  assign rd_en = !reset && (state_q == LOAD || state_q == RMW_RD);
  assign wr_en = !reset && (state_q == WRITE);

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_read   = rd_en;
  assign bus.mem_write  = wr_en;
  assign bus.mem_addr   = (rd_en || wr_en) ? 32'(addr_q >> 2) : 32'h0;
  assign bus.mem_wdata  = wr_en ? merged_q : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word-array memory model initialised to word i = i.
module tb_load_store_unit;
  localparam int MEM_WORDS = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mem_init = 1'b1;
  int   wr_count = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] mem [MEM_WORDS];

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus();
  load_store_unit #(.MEM_WORDS(MEM_WORDS), .ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always_comb
    bus.mem_rdata = (bus.mem_read && bus.mem_addr < MEM_WORDS) ? mem[bus.mem_addr[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= i;
    end else if (bus.mem_write && bus.mem_addr < MEM_WORDS) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  // Issues one request from IDLE and steps until resp_valid (bounded), logging memory activity.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output int nrd, output int nwr,
                        output logic [31:0] raddr, output logic [31:0] waddr, output logic [31:0] wd);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1; nrd = 0; nwr = 0; raddr = '0; waddr = '0; wd = '0;
    while (!bus.resp_valid && lat < 20) begin
      if (bus.mem_read)  begin nrd++; raddr = bus.mem_addr; end
      if (bus.mem_write) begin nwr++; waddr = bus.mem_addr; wd = bus.mem_wdata; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_init = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 10000", {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write}); end
    n_cmp++; if ({bus.resp_rdata, bus.mem_addr, bus.mem_wdata} !== 96'h0) begin
      n_bad++; $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0", bus.resp_rdata, bus.mem_addr, bus.mem_wdata); end
    reset = 1'b0; mem_init = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    int lat, nrd, nwr; logic [31:0] ra, wa, wd;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, nrd, nwr, ra, wa, wd);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
    n_cmp++; if (nrd !== 1 || nwr !== 0 || ra !== 32'd4) begin
      n_bad++; $display("FAIL lw_mem: reads=%0d writes=%0d addr=%h want 1/0/4", nrd, nwr, ra); end
    n_cmp++; if (bus.resp_rdata !== 32'h4 || bus.resp_err !== 1'b0) begin
      n_bad++; $display("FAIL lw_data: got %h err=%b want 00000004 err=0", bus.resp_rdata, bus.resp_err); end
    pop();
    n_cmp++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_bad++; $display("FAIL lw_to_idle: resp_valid=%b req_ready=%b want 0/1", bus.resp_valid, bus.req_ready); end
  endtask

  task automatic test_sw_loads();
    int lat, nrd, nwr; logic [31:0] ra, wa, wd;
    logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] ads  [5] = '{32'h20, 32'h20, 32'h22, 32'h20, 32'h23};
    logic [31:0] exps [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00001234, 32'h00005680, 32'h00000012};
    do_req(1'b1, 3'b010, 32'h20, 32'h12345680, lat, nrd, nwr, ra, wa, wd);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sw_latency: got %0d want 2", lat); end
    n_cmp++; if (nwr !== 1 || nrd !== 0 || wa !== 32'd8 || wd !== 32'h12345680) begin
      n_bad++; $display("FAIL sw_mem: writes=%0d reads=%0d addr=%h data=%h want 1/0/8/12345680", nwr, nrd, wa, wd); end
    n_cmp++; if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
      n_bad++; $display("FAIL sw_resp: got %h err=%b want 0 err=0", bus.resp_rdata, bus.resp_err); end
    pop();
    for (int i = 0; i < 5; i++) begin
      do_req(1'b0, f3s[i], ads[i], 32'h0, lat, nrd, nwr, ra, wa, wd);
      n_cmp++; if (bus.resp_rdata !== exps[i] || bus.resp_err !== 1'b0 || lat !== 2) begin
        n_bad++; $display("FAIL subword_load[%0d]: got %h err=%b lat=%0d want %h err=0 lat=2",
                          i, bus.resp_rdata, bus.resp_err, lat, exps[i]); end
      pop();
    end
  endtask

  task automatic test_sb_sh_rmw();
    int lat, nrd, nwr; logic [31:0] ra, wa, wd;
    do_req(1'b1, 3'b000, 32'h21, 32'h000000AB, lat, nrd, nwr, ra, wa, wd);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL sb_latency: got %0d want 3", lat); end
    n_cmp++; if (nrd !== 1 || nwr !== 1 || wa !== 32'd8 || wd !== 32'h1234AB80) begin
      n_bad++; $display("FAIL sb_mem: reads=%0d writes=%0d addr=%h data=%h want 1/1/8/1234AB80", nrd, nwr, wa, wd); end
    pop();
    do_req(1'b0, 3'b010, 32'h20, 32'h0, lat, nrd, nwr, ra, wa, wd);
    n_cmp++; if (bus.resp_rdata !== 32'h1234AB80) begin
      n_bad++; $display("FAIL sb_readback: got %h want 1234AB80", bus.resp_rdata); end
    pop();
    do_req(1'b1, 3'b001, 32'h2A, 32'hFFFFBEEF, lat, nrd, nwr, ra, wa, wd);
    n_cmp++; if (lat !== 3 || nwr !== 1 || wa !== 32'd10 || wd !== 32'hBEEF000A) begin
      n_bad++; $display("FAIL sh_mem: lat=%0d writes=%0d addr=%h data=%h want 3/1/a/BEEF000A", lat, nwr, wa, wd); end
    pop();
  endtask

  task automatic test_misalign();
    int lat, nrd, nwr; logic [31:0] ra, wa, wd;
    do_req(1'b0, 3'b010, 32'h22, 32'h0, lat, nrd, nwr, ra, wa, wd);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++; if (bus.resp_err !== 1'b1 || nrd !== 0 || lat !== 1 || bus.resp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL misalign_lw: err=%b reads=%0d lat=%0d data=%h want 1/0/1/0", bus.resp_err, nrd, lat, bus.resp_rdata); end
`else
    n_cmp++; if (bus.resp_err !== 1'b0 || nrd !== 1 || ra !== 32'd8 || bus.resp_rdata !== 32'h1234AB80) begin
      n_bad++; $display("FAIL misalign_lw: err=%b reads=%0d addr=%h data=%h want 0/1/8/1234AB80", bus.resp_err, nrd, ra, bus.resp_rdata); end
`endif
    pop();
  endtask

  task automatic test_faults();
    int lat, nrd, nwr; logic [31:0] ra, wa, wd;
    do_req(1'b0, 3'b010, 32'd4000, 32'h0, lat, nrd, nwr, ra, wa, wd);
    n_cmp++; if (bus.resp_err !== 1'b1 || lat !== 1 || nrd !== 0 || bus.resp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL range_fault: err=%b lat=%0d reads=%0d data=%h want 1/1/0/0", bus.resp_err, lat, nrd, bus.resp_rdata); end
    pop();
    do_req(1'b0, 3'b010, 32'd3996, 32'h0, lat, nrd, nwr, ra, wa, wd);
    n_cmp++; if (bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'd999) begin
      n_bad++; $display("FAIL last_word: err=%b data=%h want 0/3e7", bus.resp_err, bus.resp_rdata); end
    pop();
    do_req(1'b0, 3'b011, 32'h0, 32'h0, lat, nrd, nwr, ra, wa, wd);
    n_cmp++; if (bus.resp_err !== 1'b1 || nrd !== 0 || lat !== 1) begin
      n_bad++; $display("FAIL bad_funct3: err=%b reads=%0d lat=%0d want 1/0/1", bus.resp_err, nrd, lat); end
    pop();
    do_req(1'b1, 3'b100, 32'h30, 32'h55, lat, nrd, nwr, ra, wa, wd);
    n_cmp++; if (bus.resp_err !== 1'b1 || nwr !== 0 || nrd !== 0) begin
      n_bad++; $display("FAIL store_bu: err=%b writes=%0d reads=%0d want 1/0/0", bus.resp_err, nwr, nrd); end
    pop();
  endtask

  task automatic test_backpressure();
    int lat, nrd, nwr; logic [31:0] ra, wa, wd;
    int bad;
    bus.resp_ready = 1'b0;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, lat, nrd, nwr, ra, wa, wd);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h0; bus.req_wdata = 32'hDEADBEEF;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h4 || bus.resp_err !== 1'b0 ||
          bus.req_ready !== 1'b0 || bus.mem_write !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL backpressure_hold: %0d unstable cycles want 0", bad); end
    bus.req_valid = 1'b0;
    pop();
    n_cmp++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || mem[0] !== 32'h0) begin
      n_bad++; $display("FAIL backpressure_release: resp_valid=%b req_ready=%b mem0=%h want 0/1/0", bus.resp_valid, bus.req_ready, mem[0]); end
  endtask

  task automatic test_reset_mid_rmw();
    int w0, wr_seen;
    w0 = wr_count; wr_seen = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h24; bus.req_wdata = 32'h000000CC;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_cmp++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'd9) begin
      n_bad++; $display("FAIL rmw_rd_phase: mem_read=%b addr=%h want 1/9", bus.mem_read, bus.mem_addr); end
    reset = 1'b1;
    #1;
    if (bus.mem_write) wr_seen++;
    @(posedge clk); #1;
    n_cmp++; if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} !== 5'b10000 ||
                 {bus.resp_rdata, bus.mem_addr, bus.mem_wdata} !== 96'h0) begin
      n_bad++; $display("FAIL reset_mid_rmw: ctrl=%b rdata=%h addr=%h wdata=%h want 10000/0/0/0",
                        {bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write},
                        bus.resp_rdata, bus.mem_addr, bus.mem_wdata); end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.mem_write) wr_seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (wr_seen !== 0 || wr_count !== w0 || mem[9] !== 32'd9) begin
      n_bad++; $display("FAIL reset_no_write: strobes=%0d writes=%0d word9=%h want 0/%0d/9", wr_seen, wr_count, mem[9], w0); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b1;
    test_reset();
    test_lw();
    test_sw_loads();
    test_sb_sh_rmw();
    test_misalign();
    test_faults();
    test_backpressure();
    test_reset_mid_rmw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
